// File: rtl/edge_pulse_bank_if.sv
// edge_pulse_bank_if: level/mode/pulse bundle for edge_pulse_bank.
//   in      : level inputs, bit i = channel i
//   mode    : per-channel edge mode in mode[2i+1:2i] (00 off, 01 rise, 10 fall, 11 both)
//   out     : one-cycle pulse per channel
//   any_out : OR of all out bits
//   master drives in/mode, slave (the pulser) drives out/any_out.
interface edge_pulse_bank_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   in;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   out;
    logic               any_out;
    modport master (output in, mode, input out, any_out);
    modport slave  (input in, mode, output out, any_out);
endinterface

// File: rtl/edge_pulse_bank.sv
// edge_pulse_bank: multi-channel level-to-pulse converter with per-channel edge mode.
//   clk   : clock
//   reset : synchronous, active-high; clears sampling chains, history and hold-off counters
//   bus   : edge_pulse_bank_if slave (in, mode -> out, any_out)
//   Optional macro EDGE_HOLDOFF_EN adds a per-channel hold-off counter of HOLDOFF cycles.
module edge_pulse_bank #(
    parameter int WIDTH   = 4,
    parameter int STAGES  = 1,
    parameter int HOLDOFF = 8
) (
    input logic              clk,
    input logic              reset,
    edge_pulse_bank_if.slave bus
);
    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] s, h, hit, blocked, pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < STAGES; j++) chain[j] <= '0;
            h <= '0;
        end else begin
            chain[0] <= bus.in;
            for (int j = 1; j < STAGES; j++) chain[j] <= chain[j-1];
            h <= s;
        end
    end

    assign s = chain[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign hit[i] = (s[i] & ~h[i] & bus.mode[2*i]) | (~s[i] & h[i] & bus.mode[2*i+1]);
    end

    // Gate with reset so no pulse escapes while registers are being cleared.
    assign pulse       = hit & ~blocked & {WIDTH{~reset}};
    assign bus.out     = pulse;
    assign bus.any_out = |pulse;

`ifdef EDGE_HOLDOFF_EN
    localparam int CW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
    logic [CW-1:0] cnt [WIDTH];

    always_ff @(posedge clk) begin
        for (int j = 0; j < WIDTH; j++) begin
            if (reset)
                cnt[j] <= '0;
            else if (pulse[j])
                cnt[j] <= CW'(HOLDOFF);
            else if (cnt[j] != '0)
                cnt[j] <= cnt[j] - 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_blk
        assign blocked[i] = cnt[i] != '0;
    end
`else
    // No counters: never blocked (HOLDOFF is non-negative, so this is all zeros).
    assign blocked = {WIDTH{HOLDOFF < 0}};
`endif
endmodule

// File: tb/tb_edge_pulse_bank.sv
// tb_edge_pulse_bank: directed + random check of edge_pulse_bank (STAGES=1 and STAGES=3) against a level-history model.
module tb_edge_pulse_bank;
    localparam int W  = 4;
    localparam int HO = 8;

    typedef int last_t [W];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0]   in_v = '0;
    logic [2*W-1:0] mode_v = 8'h55;

    always #5 clk = ~clk;

    edge_pulse_bank_if #(.WIDTH(W)) b1 ();
    edge_pulse_bank_if #(.WIDTH(W)) b3 ();

    assign b1.in = in_v;
    assign b1.mode = mode_v;
    assign b3.in = in_v;
    assign b3.mode = mode_v;

    edge_pulse_bank #(.WIDTH(W), .STAGES(1), .HOLDOFF(HO)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    edge_pulse_bank #(.WIDTH(W), .STAGES(3), .HOLDOFF(HO)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    int n = 0;
    int checks = 0;
    int fails = 0;
    logic [W-1:0] in_h [4096];
    bit rst_h [4096];
    last_t last1, last3;

    // Level seen at the last sampling stage after edge e: the input from STAGES-1 edges earlier,
    // or 0 if any of those edges (or the time before the first edge) was under reset.
    function automatic logic [W-1:0] level(int st, int e);
        for (int k = e - st + 1; k <= e; k++)
            if (k < 1 || rst_h[k]) return '0;
        return in_h[e - st + 1];
    endfunction

    function automatic logic [W-1:0] exp_out(int st, last_t last);
        logic [W-1:0] cur, prev, r;
        cur = level(st, n);
        prev = rst_h[n] ? '0 : level(st, n - 1);
        r = '0;
        for (int i = 0; i < W; i++) begin
            logic e;
            logic blk;
            e = (cur[i] && !prev[i] && mode_v[2*i]) || (!cur[i] && prev[i] && mode_v[2*i+1]);
`ifdef EDGE_HOLDOFF_EN
            blk = (n - last[i]) <= HO;
`else
            blk = 1'b0;
`endif
            r[i] = e && !blk && !reset;
        end
        return r;
    endfunction

    task automatic cyc();
        logic [W-1:0] e1, e3;
        @(posedge clk);
        n++;
        in_h[n] = in_v;
        rst_h[n] = reset;
        if (reset)
            for (int i = 0; i < W; i++) begin
                last1[i] = -100000;
                last3[i] = -100000;
            end
        @(negedge clk);
        e1 = exp_out(1, last1);
        e3 = exp_out(3, last3);
        checks++;
        assert (b1.out === e1) else begin
            fails++;
            $error("FAIL out_s1 cycle %0d: got %b expected %b", n, b1.out, e1);
        end
        checks++;
        assert (b1.any_out === |e1) else begin
            fails++;
            $error("FAIL any_s1 cycle %0d: got %b expected %b", n, b1.any_out, |e1);
        end
        checks++;
        assert (b3.out === e3) else begin
            fails++;
            $error("FAIL out_s3 cycle %0d: got %b expected %b", n, b3.out, e3);
        end
        checks++;
        assert (b3.any_out === |e3) else begin
            fails++;
            $error("FAIL any_s3 cycle %0d: got %b expected %b", n, b3.any_out, |e3);
        end
        for (int i = 0; i < W; i++) begin
            if (e1[i]) last1[i] = n;
            if (e3[i]) last3[i] = n;
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin
            last1[i] = -100000;
            last3[i] = -100000;
        end
        // reset and idle, then a single rising input
        reset = 1'b1; in_v = '0; mode_v = 8'h55;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        in_v = 4'b0001;
        repeat (5) cyc();
        // mode decode: ch0 off, ch1 rise, ch2 fall, ch3 both
        in_v = '0;
        repeat (4) cyc();
        mode_v = 8'b11_10_01_00;
        repeat (2) cyc();
        in_v = 4'b1111;
        repeat (10) cyc();
        in_v = 4'b0000;
        repeat (10) cyc();
        // one-cycle input pulse in both and rising modes
        in_v = 4'b1010;
        cyc();
        in_v = '0;
        repeat (6) cyc();
        // depth: in[2] rising
        mode_v = 8'h55;
        in_v = 4'b0100;
        repeat (6) cyc();
        in_v = '0;
        repeat (4) cyc();
        // high at reset release
        reset = 1'b1; in_v = 4'b1111;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (6) cyc();
        in_v = '0;
        repeat (4) cyc();
        // hold-off window: toggle in[1] every 2 cycles, reset mid-window
        for (int t = 0; t < 30; t++) begin
            if (t % 2 == 0) in_v[1] = ~in_v[1];
            cyc();
        end
        in_v[1] = 1'b1;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        in_v[1] = 1'b0;
        cyc();
        for (int t = 0; t < 30; t++) begin
            if (t % 2 == 0) in_v[1] = ~in_v[1];
            cyc();
        end
        // mode change alone must not create an edge
        in_v = 4'b0101;
        repeat (5) cyc();
        mode_v = 8'hAA;
        repeat (2) cyc();
        mode_v = 8'hFF;
        repeat (2) cyc();
        // random traffic
        for (int t = 0; t < 400; t++) begin
            in_v = W'($urandom);
            if ($urandom_range(0, 7) == 0) mode_v = 8'($urandom);
            reset = $urandom_range(0, 39) == 0;
            cyc();
        end
        reset = 1'b0;
        repeat (4) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/edge_pulse_bank.md
# edge_pulse_bank

Multi-channel level-to-pulse converter for the pairing core's control path. Each channel watches a level signal, such as a sub-unit "done" or "ready" flag, and emits a single-cycle pulse on a selected edge. The pulses drive the start inputs of downstream arithmetic units. The block generalises the single-channel rising-edge pulser: parametric channel count and sampling depth, per-channel edge mode, and an optional per-channel hold-off window that suppresses re-triggering.

## Interface
Parameters:
- `WIDTH`, default 4: number of independent channels (≥1).
- `STAGES`, default 1: input sampling register stages per channel (≥1).
- `HOLDOFF`, default 8: hold-off length in cycles after a pulse (≥0). Used only with `EDGE_HOLDOFF_EN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in` in `WIDTH`: level inputs, bit i = channel i.
- `mode` in `2*WIDTH`: edge mode for channel i in `mode[2i+1:2i]`.
  - 00: off.
  - 01: rising.
  - 10: falling.
  - 11: both.
- `out` out `WIDTH`: one-cycle pulse per channel.
- `any_out` out 1: OR of all `out` bits.

## Operation
- Per channel there is a shift chain of `STAGES` registers fed by `in[i]`, followed by one history register `h` that holds the previous value of the last stage `s`.
- Edge definitions:
  - rise = `s & ~h`.
  - fall = `~s & h`.
  - edge = (rise & `mode` bit0) | (fall & `mode` bit1).
- `out[i]` = edge & `~blocked[i]`, decoded combinationally from registers and `mode`.
  - `blocked[i]` is constant 0 without `EDGE_HOLDOFF_EN`.
- `mode` is not registered.
  - Changing `mode` never creates an edge by itself.
  - Changing `mode` only gates the decode of the current `s`/`h` pair.
- Channels are fully independent. Simultaneous edges on any number of channels all pulse in the same cycle.
- Reset clears every chain register, every `h`, and every hold-off counter.
  - An input already high when reset deasserts therefore yields a rising pulse, as the legacy pulser does.
- Reset asserted mid-pulse or mid-hold-off aborts it. `out` is 0 during reset.

## Timing
- Reset value: `out` = 0 and `any_out` = 0 while `reset` is high and in the first cycle after release.
- Latency: `in[i]` changes before clock edge k. With a matching mode, `out[i]` is high for exactly the cycle between edges k+`STAGES`-1 and k+`STAGES`.
  - With `STAGES`=1, that is the cycle right after the first sampling edge.
- Pulse width is always exactly one cycle, regardless of how long the level holds.
- An input pulse of one cycle yields:
  - rising mode: one pulse.
  - both mode: two pulses on consecutive cycles.
- Throughput: one edge per channel per cycle, with no hold-off.
- `any_out` is combinational from `out`, with no added latency.

## Configuration
- Macro `EDGE_HOLDOFF_EN`.
- Defined: each channel has a down-counter of width `$clog2(HOLDOFF+1)`, where `blocked[i]` = counter≠0.
  - When `out[i]` fires, the counter loads `HOLDOFF`.
  - While nonzero, the counter decrements by 1 per cycle.
  - Edges seen while blocked are dropped, not queued.
  - The next pulse is possible no earlier than `HOLDOFF`+1 cycles after the previous one.
  - `HOLDOFF`=0 means no suppression.
- Undefined: no counters are instantiated. The block detects edges only.

## Test plan
- Reset and idle:
  - Hold `reset`=1 for 3 cycles with `in`=4'b0000 and `mode`=8'h55, then release. `out`=0 throughout.
  - Set `in[0]`=1 at cycle 5 with `STAGES`=1. `out`=4'b0001 in cycle 6 only.
- Mode decode:
  - `mode`=8'b11_10_01_00. Toggle all `in` 0→1 at cycle 10, then 1→0 at cycle 20.
  - Rising edge: `out`=4'b1010 for one cycle.
  - Falling edge: `out`=4'b1100 for one cycle.
  - `any_out` matches `out` in both cases.
- Depth: `STAGES`=3, rising mode. `in[2]` rises before edge 10. `out[2]` is high in the cycle after edge 12 only.
- High at reset release: `in`=4'b1111 during reset, `mode`=8'h55. `out`=4'b1111 for one cycle after release, then 0.
- Hold-off (`EDGE_HOLDOFF_EN`, `HOLDOFF`=8, rising mode):
  - Toggle `in[1]` every 2 cycles for 30 cycles.
  - `out[1]` pulses only on rises at least 9 cycles after the previous pulse.
  - Assert `reset` mid-window. The first rise after release pulses immediately.
- Macro off: same stimulus as the hold-off scenario without `EDGE_HOLDOFF_EN`. Every rise pulses, one pulse per 2-cycle toggle pair.
